// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : RISC-V execute-stage ALU feeding a two-entry skid buffer with
//            valid/ready handshakes and a registered upstream ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       rd_out,
  output logic             reg_write_out
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SLT = 3'b101;

  // Entry layout: {reg_write, rd[4:0], zero, result[WIDTH-1:0]}
  localparam int c_EW = WIDTH + 7;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [c_EW-1:0]  r_main;
  logic [c_EW-1:0]  r_skid;

  logic [WIDTH-1:0] w_res;
  logic             w_slt;
  logic             w_zero;
  logic [c_EW-1:0]  w_in_entry;
  logic             w_accept;
  logic             w_drain;

  assign w_slt = ($signed(a) < $signed(b));

  always_comb begin
    w_res = '0;
    case (alu_op)
      c_OP_ADD: w_res = a + b;
      c_OP_SUB: w_res = a - b;
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_XOR: w_res = a ^ b;
      c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      default:  w_res = '0;
    endcase
  end

  assign w_zero     = (w_res == '0);
  assign w_in_entry = {reg_write, rd, w_zero, w_res};
  assign w_accept   = in_valid & r_in_ready;
  assign w_drain    = r_out_valid & out_ready;

  // Ready and valid are registered from the next state so neither side sees
  // a combinational path through the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_in_entry;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_main <= w_in_entry;
          end else if (w_accept) begin
            r_skid     <= w_in_entry;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (w_drain) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_drain) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign result        = r_main[WIDTH-1:0];
  assign zero          = r_main[WIDTH];
  assign rd_out        = r_main[WIDTH+5:WIDTH+1];
  assign reg_write_out = r_main[WIDTH+6];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Self-checking bench for alu_exec_stage: directed vectors plus a
//            valid/ready stress run against a FIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a, b;
  logic [4:0]       rd;
  logic             reg_write;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [4:0]       rd_out;
  logic             reg_write_out;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .rd(rd), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .rd_out(rd_out),
    .reg_write_out(reg_write_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb, input logic [4:0] vrd,
                       input logic vrw);
    in_valid  = 1'b1;
    alu_op    = op;
    a         = va;
    b         = vb;
    rd        = vrd;
    reg_write = vrw;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ov"},  {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir"},  {31'd0, in_ready}, 32'd1);
    chk({tag, "_res"}, result, 32'd0);
    chk({tag, "_z"},   {31'd0, zero}, 32'd0);
    chk({tag, "_rd"},  {27'd0, rd_out}, 32'd0);
    chk({tag, "_rw"},  {31'd0, reg_write_out}, 32'd0);
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
      input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // Directed single-op vectors: op, a, b, expected result, expected zero
  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] res;
    logic             z;
  } vec_t;

  vec_t vecs[7];

  logic [37:0] q[$];

  initial begin
    int accepted;
    int cycles;
    logic acc, drn, hold;
    logic [WIDTH-1:0] prev_res;
    logic [37:0] exp_e;
    logic [2:0] rop;
    logic [WIDTH-1:0] ra, rb;

    vecs[0] = '{3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[2] = '{3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[3] = '{3'b100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0};
    vecs[4] = '{3'b001, 32'd5,         32'd5,         32'd0,         1'b1};
    vecs[5] = '{3'b110, 32'd7,         32'd3,         32'd0,         1'b1};
    vecs[6] = '{3'b011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; a = '0; b = '0; rd = '0; reg_write = 1'b0;
    tick(); tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // ADD 7+5 with one-cycle latency
    drive(3'b000, 32'd7, 32'd5, 5'd3, 1'b1);
    tick();
    chk("add_ov",  {31'd0, out_valid}, 32'd1);
    chk("add_res", result, 32'd12);
    chk("add_z",   {31'd0, zero}, 32'd0);
    chk("add_rd",  {27'd0, rd_out}, 32'd3);
    chk("add_rw",  {31'd0, reg_write_out}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].op, vecs[i].va, vecs[i].vb, 5'(i + 1), i[0]);
      tick();
      chk($sformatf("v%0d_ov", i),  {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_res", i), result, vecs[i].res);
      chk($sformatf("v%0d_z", i),   {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_rd", i),  {27'd0, rd_out}, 32'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_ov", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back ADDs with out_ready low
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd1, 5'd1, 1'b1);
    tick();
    chk("bp1_ir",  {31'd0, in_ready}, 32'd1);
    chk("bp1_res", result, 32'd2);
    drive(3'b000, 32'd2, 32'd2, 5'd2, 1'b1);
    tick();
    chk("bp2_ir",  {31'd0, in_ready}, 32'd0);
    chk("bp2_res", result, 32'd2);
    drive(3'b000, 32'd3, 32'd3, 5'd3, 1'b1);
    tick();
    chk("bp3_ir",  {31'd0, in_ready}, 32'd0);
    chk("bp3_res", result, 32'd2);
    out_ready = 1'b1;
    tick();
    chk("bp4_ov",  {31'd0, out_valid}, 32'd1);
    chk("bp4_res", result, 32'd4);
    chk("bp4_ir",  {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp5_res", result, 32'd6);
    chk("bp5_rd",  {27'd0, rd_out}, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("bp6_ov", {31'd0, out_valid}, 32'd0);

    // Flush while full with a live input on the same cycle
    out_ready = 1'b0;
    drive(3'b000, 32'd10, 32'd10, 5'd4, 1'b1); tick();
    drive(3'b000, 32'd20, 32'd20, 5'd5, 1'b1); tick();
    chk("fl_pre_ir", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(3'b000, 32'd99, 32'd1, 5'd6, 1'b1);
    tick();
    chk("fl_ov", {31'd0, out_valid}, 32'd0);
    chk("fl_ir", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_post_ov", {31'd0, out_valid}, 32'd0);

    // Reset while full
    out_ready = 1'b0;
    drive(3'b010, 32'hFF, 32'h0F, 5'd7, 1'b1); tick();
    drive(3'b011, 32'hF0, 32'h0F, 5'd8, 1'b1); tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check_reset_vals("rst2");
    rst = 1'b0; out_ready = 1'b1;
    drive(3'b000, 32'd9, 32'd1, 5'd9, 1'b1);
    tick();
    chk("rst2_add_ov",  {31'd0, out_valid}, 32'd1);
    chk("rst2_add_res", result, 32'd10);
    in_valid = 1'b0;
    tick();

    // Random valid/ready stress against an in-order reference queue
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      rop = 3'($urandom_range(7));
      ra  = $urandom;
      rb  = ($urandom_range(3) == 0) ? ra : $urandom;
      drive(rop, ra, rb, 5'($urandom_range(31)), 1'($urandom_range(1)));
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      acc  = in_valid & in_ready;
      drn  = out_valid & out_ready;
      hold = out_valid & ~out_ready;
      prev_res = result;
      if (drn) begin
        if (q.size() == 0) begin
          chk("st_spurious", 32'd1, 32'd0);
        end else begin
          exp_e = q.pop_front();
          chk("st_res", result, exp_e[31:0]);
          chk("st_tag", {26'd0, reg_write_out, rd_out},
              {26'd0, exp_e[37:32]});
          chk("st_z", {31'd0, zero}, {31'd0, (exp_e[31:0] == '0)});
        end
      end
      if (acc) begin
        q.push_back({reg_write, rd, ref_alu(rop, ra, rb)});
        accepted++;
      end
      tick();
      cycles++;
      if (hold) chk("st_stable", result, prev_res);
      chk("st_ov", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    end
    if (accepted < 1000) chk("st_timeout", 32'(accepted), 32'd1000);

    in_valid = 1'b0; out_ready = 1'b1;
    cycles = 0;
    while (q.size() != 0 && cycles < 10) begin
      if (out_valid) begin
        exp_e = q.pop_front();
        chk("fin_res", result, exp_e[31:0]);
      end
      tick();
      cycles++;
    end
    chk("fin_left", 32'(q.size()), 32'd0);
    chk("fin_ov", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
